// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue sequencer: opcodes, unit select, FSM states.
package fpu_pkg;

    // Decoder opcode field
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_MUL     = 3'b010;
    localparam logic [2:0] OP_DIV     = 3'b011;
    localparam logic [2:0] OP_SQRT    = 3'b100;
    localparam logic [2:0] OP_CVT_WS  = 3'b101;
    localparam logic [2:0] OP_CVT_SW  = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    // Execution unit select
    localparam logic [1:0] UNIT_FP   = 2'd0;
    localparam logic [1:0] UNIT_SQRT = 2'd1;
    localparam logic [1:0] UNIT_INT  = 2'd2;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

endpackage

// File: rtl/fpu_op_decode.sv
// Opcode -> unit select, unit sub-op and timeout compare value (budget - 1).
module fpu_op_decode
    import fpu_pkg::*;
#(
    parameter int CNT_W        = 6,
    parameter int FP_TIMEOUT   = 8,
    parameter int SQRT_TIMEOUT = 40,
    parameter int INT_TIMEOUT  = 4
) (
    input  logic [2:0]       op,
    output logic             legal,
    output logic [1:0]       unit_sel,
    output logic [1:0]       unit_op,
    output logic [CNT_W-1:0] tlim
);

    // Pure lookup; the sequencer never inspects the opcode itself
    always_comb begin
        legal    = 1'b1;
        unit_sel = UNIT_FP;
        unit_op  = op[1:0];
        tlim     = CNT_W'(FP_TIMEOUT - 1);
        case (op)
            OP_SQRT: begin
                unit_sel = UNIT_SQRT;
                unit_op  = 2'd0;
                tlim     = CNT_W'(SQRT_TIMEOUT - 1);
            end
            OP_CVT_WS: begin
                unit_sel = UNIT_INT;
                unit_op  = 2'd0;
                tlim     = CNT_W'(INT_TIMEOUT - 1);
            end
            OP_CVT_SW: begin
                unit_sel = UNIT_INT;
                unit_op  = 2'd1;
                tlim     = CNT_W'(INT_TIMEOUT - 1);
            end
            OP_ILLEGAL: begin
                legal   = 1'b0;
                unit_op = 2'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fpu_sequencer.sv
// Single-issue FP sequencer: routes one op to its unit, stalls the CPU until
// the unit finishes (or times out), then does the one regfile writeback.
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int W            = 32,
    parameter int FP_TIMEOUT   = 8,
    parameter int SQRT_TIMEOUT = 40,
    parameter int INT_TIMEOUT  = 4,
    parameter int CNT_W        = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         issue_valid,
    input  logic [2:0]   issue_op,
    input  logic [4:0]   issue_rd,
    input  logic [W-1:0] issue_a,
    input  logic [W-1:0] issue_b,
    output logic         stall,
    output logic [W-1:0] unit_a,
    output logic [W-1:0] unit_b,
    output logic [1:0]   unit_op,
    output logic         fp_start,
    output logic         sqrt_start,
    output logic         int_start,
    input  logic         fp_done,
    input  logic [W-1:0] fp_result,
    input  logic         sqrt_done,
    input  logic [W-1:0] sqrt_result,
    input  logic         int_done,
    input  logic [W-1:0] int_result,
    output logic         wb_valid,
    output logic [4:0]   wb_rd,
    output logic [W-1:0] wb_data,
    output logic         err
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tlim_q, tlim_d;
    logic [1:0]       sel_q, sel_d;
    logic [4:0]       rd_q, rd_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, data_q, data_d;
    logic [1:0]       uop_q, uop_d;
    logic             fp_start_q, fp_start_d;
    logic             sqrt_start_q, sqrt_start_d;
    logic             int_start_q, int_start_d;
    logic             wb_valid_q, wb_valid_d;
    logic             err_q, err_d;

    logic             dec_legal;
    logic [1:0]       dec_sel;
    logic [1:0]       dec_uop;
    logic [CNT_W-1:0] dec_tlim;
    logic             sel_done;
    logic [W-1:0]     sel_result;

    fpu_op_decode #(
        .CNT_W        (CNT_W),
        .FP_TIMEOUT   (FP_TIMEOUT),
        .SQRT_TIMEOUT (SQRT_TIMEOUT),
        .INT_TIMEOUT  (INT_TIMEOUT)
    ) u_dec (
        .op       (issue_op),
        .legal    (dec_legal),
        .unit_sel (dec_sel),
        .unit_op  (dec_uop),
        .tlim     (dec_tlim)
    );

    // Only the selected unit's done/result is visible; others are ignored
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        case (sel_q)
            UNIT_FP:   begin sel_done = fp_done;   sel_result = fp_result;   end
            UNIT_SQRT: begin sel_done = sqrt_done; sel_result = sqrt_result; end
            UNIT_INT:  begin sel_done = int_done;  sel_result = int_result;  end
            default: ;
        endcase
    end

    // Next-state: pulses default low, latched operands hold until the next accept
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tlim_d       = tlim_q;
        sel_d        = sel_q;
        rd_d         = rd_q;
        a_d          = a_q;
        b_d          = b_q;
        uop_d        = uop_q;
        data_d       = data_q;
        fp_start_d   = 1'b0;
        sqrt_start_d = 1'b0;
        int_start_d  = 1'b0;
        wb_valid_d   = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    if (dec_legal) begin
                        rd_d         = issue_rd;
                        a_d          = issue_a;
                        b_d          = issue_b;
                        uop_d        = dec_uop;
                        sel_d        = dec_sel;
                        tlim_d       = dec_tlim;
                        fp_start_d   = (dec_sel == UNIT_FP);
                        sqrt_start_d = (dec_sel == UNIT_SQRT);
                        int_start_d  = (dec_sel == UNIT_INT);
                        state_d      = ST_START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WB;
                    end
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                // done takes priority over a timeout in the same cycle
                if (sel_done) begin
                    data_d     = sel_result;
                    wb_valid_d = 1'b1;
                    state_d    = ST_WB;
                end else if (cnt_q == tlim_q) begin
                    err_d   = 1'b1;
                    state_d = ST_WB;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tlim_q       <= '0;
            sel_q        <= UNIT_FP;
            rd_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            uop_q        <= '0;
            data_q       <= '0;
            fp_start_q   <= 1'b0;
            sqrt_start_q <= 1'b0;
            int_start_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tlim_q       <= tlim_d;
            sel_q        <= sel_d;
            rd_q         <= rd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            uop_q        <= uop_d;
            data_q       <= data_d;
            fp_start_q   <= fp_start_d;
            sqrt_start_q <= sqrt_start_d;
            int_start_q  <= int_start_d;
            wb_valid_q   <= wb_valid_d;
            err_q        <= err_d;
        end
    end

    assign stall      = issue_valid && (state_q != ST_WB);
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign unit_op    = uop_q;
    assign fp_start   = fp_start_q;
    assign sqrt_start = sqrt_start_q;
    assign int_start  = int_start_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = rd_q;
    assign wb_data    = data_q;
    assign err        = err_q;

endmodule

// File: doc/fpu_sequencer.md
Name: fpu_sequencer

Overview:
Multi-cycle issue controller placed between the instruction decoder and the FPU execution units (fp add/sub/mul/div, sqrt, int<->float convert).
- Accepts one FP instruction at a time and routes it to the correct unit.
- Stalls the CPU (holds the PC) until that unit reports done.
- Performs the single FP register-file writeback.
- Aborts with an error pulse if a unit exceeds its cycle budget.

Parameters:
W, 32, operand/result width
FP_TIMEOUT, 8, max cycles from fp_start to fp_done
SQRT_TIMEOUT, 40, max cycles from sqrt_start to sqrt_done
INT_TIMEOUT, 4, max cycles from int_start to int_done
CNT_W, 6, timeout counter width; must satisfy 2^CNT_W > max timeout

Ports:
clk  in  1  system clock (the CPU clock)
reset  in  1  synchronous, active-high reset
issue_valid  in  1  decoder presents an FP instruction
issue_op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101 cvt.w.s, 110 cvt.s.w, 111 illegal
issue_rd  in  5  FP destination register
issue_a  in  W  operand A
issue_b  in  W  operand B
stall  out  1  hold PC and IF/decode
unit_a  out  W  latched operand A, shared by all units
unit_b  out  W  latched operand B, shared by all units
unit_op  out  2  sub-op for the fp unit (issue_op[1:0]) or the cvt unit (0 = cvt.w.s, 1 = cvt.s.w)
fp_start  out  1  one-cycle start pulse, fp unit
sqrt_start  out  1  one-cycle start pulse, sqrt unit
int_start  out  1  one-cycle start pulse, cvt unit
fp_done  in  1  fp unit result valid
fp_result  in  W  fp unit result
sqrt_done  in  1  sqrt unit result valid
sqrt_result  in  W  sqrt unit result
int_done  in  1  cvt unit result valid
int_result  in  W  cvt unit result
wb_valid  out  1  FP regfile write enable, one cycle
wb_rd  out  5  writeback register
wb_data  out  W  writeback data
err  out  1  one-cycle pulse: illegal op or timeout

Behaviour:
- States: IDLE, START, BUSY, WB.
- Reset (synchronous, any state including mid-operation):
  - state goes to IDLE; counter = 0.
  - All outputs 0: start pulses, wb_valid, err, unit_a/b/op, wb_rd, wb_data.
  - In-flight unit results are discarded.
- stall = issue_valid && (state != WB), combinational. It is low exactly in the WB cycle, so the PC advances there.
- IDLE:
  - If issue_valid and op != 111: latch a, b, rd, op; select the unit → START.
  - If issue_valid and op == 111 → WB with the error flag set.
- START:
  - Assert the selected unit's start for exactly one cycle (registered output).
  - Clear the counter → BUSY.
  - unit_a/unit_b/unit_op stay stable from START until WB ends.
- BUSY:
  - Counter increments each cycle.
  - If the selected unit's done = 1: capture its result into wb_data → WB (normal).
  - Else if counter == that unit's TIMEOUT − 1 → WB (timeout).
  - done and timeout in the same cycle: done wins.
  - done from a non-selected unit: ignored.
- WB (one cycle):
  - Normal: wb_valid = 1, wb_rd = latched rd, wb_data = captured result.
  - Timeout or illegal op: wb_valid = 0, err = 1.
  - Always → IDLE.
  - A new issue_valid is not sampled in the WB cycle; it is first seen in the following IDLE.
- Latency: issue accepted at cycle 0, start at cycle 1. If done is asserted N cycles after start, WB is at cycle 2+N, and stall is high for cycles 0..1+N.
- Minimum op (done the cycle after start): 3 cycles issue→WB.
- Counter saturates at its maximum value; it never wraps.

Decomposition:
- Shared package fpu_pkg:
  - opcode constants (OP_ADD..OP_ILLEGAL)
  - unit-select encoding (UNIT_FP, UNIT_SQRT, UNIT_INT)
  - state encoding
- Sub-module fpu_op_decode (combinational): maps issue_op to unit select, unit_op and timeout limit. Keeps the FSM free of opcode knowledge.

Test Plan:
- Reset, then add: issue op=000 rd=3 a=0x3F800000 b=0x40000000; fp_done with 0x40400000 three cycles after fp_start → fp_start at cycle 1, WB at cycle 5 with wb_rd=3, wb_data=0x40400000; stall high cycles 0–4, low at 5.
- sqrt that never completes (sqrt_done held 0) → err pulse exactly SQRT_TIMEOUT+1 cycles after sqrt_start; wb_valid stays 0; next issue accepted normally.
- Illegal op=111 → no start pulse, WB at cycle 1 with err=1, wb_valid=0.
- cvt.s.w op=110 with int_done on the same cycle the timeout fires → result written (wb_valid=1), err=0, unit_op=1.
- Spurious fp_done during a sqrt op, then sqrt_done with 0x40000000 → only the sqrt result is written; reset asserted mid-BUSY of a later op → next cycle all outputs 0, state IDLE, a late done is ignored.
- Back-to-back: mul then div held on issue_valid → two WB pulses, each followed by one IDLE acceptance cycle; start pulses never overlap.
